// File: rtl/tow_scoreboard.sv
// rtl/tow_scoreboard.sv - tug-of-war match scoreboard: per-round scoring, 7-seg digits, round restart, match end
module tow_scoreboard #(
    parameter int WIN_SCORE   = 7,
    parameter int HOLD_CYCLES = 4,
    parameter int HOLD_W      = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] winner,
    output logic       round_reset,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic [6:0] hex_l,
    output logic [6:0] hex_r,
    output logic       match_over,
    output logic [1:0] match_winner
);

    typedef enum logic [2:0] {
        PLAY     = 3'd0,
        HOLD     = 3'd1,
        RESTART  = 3'd2,
        WAIT_CLR = 3'd3,
        DONE     = 3'd4
    } state_t;

    localparam logic [3:0]        WIN_VAL   = 4'(WIN_SCORE);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

    state_t            state, state_nx;
    logic [HOLD_W-1:0] hold_cnt, hold_cnt_nx;
    logic [3:0]        score_l_nx, score_r_nx;
    logic              round_reset_nx;
    logic              l_won, r_won;

    assign l_won = (score_l == WIN_VAL);
    assign r_won = (score_r == WIN_VAL);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= PLAY;
            hold_cnt    <= '0;
            score_l     <= '0;
            score_r     <= '0;
            round_reset <= 1'b0;
        end else begin
            state       <= state_nx;
            hold_cnt    <= hold_cnt_nx;
            score_l     <= score_l_nx;
            score_r     <= score_r_nx;
            round_reset <= round_reset_nx;
        end
    end

    // The pulse is registered from RESTART, so it appears one edge after entering it.
    always_comb begin
        state_nx       = state;
        hold_cnt_nx    = hold_cnt;
        score_l_nx     = score_l;
        score_r_nx     = score_r;
        round_reset_nx = (state == RESTART);
        case (state)
            PLAY: begin
                if (winner == 2'b10 && !l_won) begin
                    score_l_nx  = score_l + 4'd1;
                    hold_cnt_nx = HOLD_LOAD;
                    state_nx    = HOLD;
                end else if (winner == 2'b01 && !r_won) begin
                    score_r_nx  = score_r + 4'd1;
                    hold_cnt_nx = HOLD_LOAD;
                    state_nx    = HOLD;
                end
            end
            HOLD: begin
                if (hold_cnt == '0) begin
                    state_nx = (l_won || r_won) ? DONE : RESTART;
                end else begin
                    hold_cnt_nx = hold_cnt - 1'b1;
                end
            end
            RESTART: state_nx = WAIT_CLR;
            // A winner code still asserted from the finished round must drop before play resumes.
            WAIT_CLR: begin
                if (winner == 2'b00) begin
                    state_nx = PLAY;
                end
            end
            DONE:    state_nx = DONE;
            default: state_nx = PLAY;
        endcase
    end

    assign match_over   = (state == DONE);
    assign match_winner = match_over ? {l_won, r_won & ~l_won} : 2'b00;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0010000;
            default: seg_decode = 7'b1111111;
        endcase
    endfunction

    assign hex_l = seg_decode(score_l);
    assign hex_r = seg_decode(score_r);

endmodule
